// File: rtl/cpld_ram_xbank_if.sv
// CPC expansion-bus bundle for cpld_ram_xbank: Z80 bus inputs plus SRAM decode outputs.
interface cpld_ram_xbank_if #(
  parameter int BANK_BITS = 3
);
  logic [7:0]           adr_hi;
  logic                 iorq_b;
  logic                 mreq_b;
  logic                 wr_b;
  logic [7:0]           data;
  logic                 ramdis;
  logic                 ramcs_b;
  logic [BANK_BITS+1:0] ramadrhi;
  logic                 pend;

  modport master (
    output adr_hi, iorq_b, mreq_b, wr_b, data,
    input  ramdis, ramcs_b, ramadrhi, pend
  );

  modport slave (
    input  adr_hi, iorq_b, mreq_b, wr_b, data,
    output ramdis, ramcs_b, ramadrhi, pend
  );
endinterface

// File: rtl/cpld_ram_xbank.sv
// CPC 512K..4M RAM expansion decoder with deferred mapping changes.
// Optional MREQ_DEFER_EN: hold a pending mapping until mreq_b is high at a clock edge.
module cpld_ram_xbank #(
  parameter int BANK_BITS = 3,
  parameter int NUM_BANKS = 2**BANK_BITS
) (
  input logic             clk,
  input logic             reset_b,
  cpld_ram_xbank_if.slave bus
);
  localparam int CFG_W = BANK_BITS + 3;

  typedef enum logic {IDLE, PEND} state_t;

  state_t             state;
  logic               seen_q;
  logic [CFG_W-1:0]   pend_cfg_q;
  logic [CFG_W-1:0]   act_cfg_q;

  logic               cfg_wr;
  logic               capture;
  logic               apply_ok;
  logic [13:0]        cap_wide;
  logic [CFG_W-1:0]   cap_cfg;
  logic               unused_bits;

  assign cfg_wr  = !bus.iorq_b && !bus.wr_b && !bus.adr_hi[7] && bus.data[7] && bus.data[6];
  assign capture = cfg_wr && !seen_q;

  // Extended bank bits sit directly above data[5:0], taken from A8 upward.
  assign cap_wide    = {bus.adr_hi, bus.data[5:0]};
  assign cap_cfg     = cap_wide[CFG_W-1:0];
  assign unused_bits = ^cap_wide;

`ifdef MREQ_DEFER_EN
  assign apply_ok = bus.mreq_b;
`else
  assign apply_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      seen_q     <= 1'b0;
      pend_cfg_q <= '0;
      act_cfg_q  <= '0;
    end else begin
      seen_q <= cfg_wr;
      case (state)
        IDLE: begin
          if (capture) begin
            pend_cfg_q <= cap_cfg;
            state      <= PEND;
          end
        end
        PEND: begin
          // Apply and re-capture can coincide: old value goes live, new one waits.
          if (apply_ok) act_cfg_q <= pend_cfg_q;
          if (capture) pend_cfg_q <= cap_cfg;
          else if (apply_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pend = (state == PEND);

  logic [2:0]           mode;
  logic [BANK_BITS-1:0] bank;
  logic [1:0]           page;
  logic [1:0]           blk;
  logic                 valid;
  logic                 hit;

  always_comb begin
    mode  = act_cfg_q[2:0];
    bank  = act_cfg_q[CFG_W-1:3];
    page  = bus.adr_hi[7:6];
    blk   = 2'b00;
    valid = 1'b0;
    case (mode)
      3'd0: valid = 1'b0;
      3'd1, 3'd3: begin
        valid = (page == 2'd3);
        blk   = 2'b11;
      end
      3'd2: begin
        valid = 1'b1;
        blk   = page;
      end
      default: begin
        valid = (page == 2'd1);
        blk   = mode[1:0];
      end
    endcase
    hit = valid && ({{(32-BANK_BITS){1'b0}}, bank} < NUM_BANKS);
  end

  assign bus.ramcs_b  = !(hit && !bus.mreq_b);
  assign bus.ramdis   = hit && !bus.mreq_b;
  assign bus.ramadrhi = hit ? {bank, blk} : '0;
endmodule

// File: tb/tb_cpld_ram_xbank.sv
// Bench for cpld_ram_xbank: two instances (3-bit and 5-bit/24-bank) against a behavioural model.
module tb_cpld_ram_xbank;
  logic       clk = 1'b0;
  logic       reset_b;
  logic [7:0] adr_hi;
  logic       iorq_b, mreq_b, wr_b;
  logic [7:0] data;

  int n_cmp = 0;
  int n_bad = 0;

  cpld_ram_xbank_if #(.BANK_BITS(3)) if3 ();
  cpld_ram_xbank_if #(.BANK_BITS(5)) if5 ();

  assign if3.adr_hi = adr_hi;
  assign if3.iorq_b = iorq_b;
  assign if3.mreq_b = mreq_b;
  assign if3.wr_b   = wr_b;
  assign if3.data   = data;
  assign if5.adr_hi = adr_hi;
  assign if5.iorq_b = iorq_b;
  assign if5.mreq_b = mreq_b;
  assign if5.wr_b   = wr_b;
  assign if5.data   = data;

  cpld_ram_xbank #(.BANK_BITS(3)) dut3 (.clk(clk), .reset_b(reset_b), .bus(if3));
  cpld_ram_xbank #(.BANK_BITS(5), .NUM_BANKS(24)) dut5 (.clk(clk), .reset_b(reset_b), .bus(if5));

  always #5 clk = ~clk;

  // Reference: configurations as integers (bank*8 + mode), pending flag shared by both instances.
  int  bbits [2] = '{3, 5};
  int  nbanks[2] = '{8, 24};
  int  m_act [2] = '{0, 0};
  int  m_pv  [2] = '{0, 0};
  bit  m_pend = 1'b0;
  bit  m_seen = 1'b0;
  bit  m_cw, m_cap, m_ap;

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0;
        m_pv[k]  = 0;
      end
      m_pend = 1'b0;
      m_seen = 1'b0;
    end else begin
      m_cw  = !iorq_b && !wr_b && !adr_hi[7] && data[7] && data[6];
      m_cap = m_cw && !m_seen;
`ifdef MREQ_DEFER_EN
      m_ap  = m_pend && mreq_b;
`else
      m_ap  = m_pend;
`endif
      for (int k = 0; k < 2; k++) begin
        if (m_ap) m_act[k] = m_pv[k];
        if (m_cap) m_pv[k] = (int'(adr_hi) % (1 << (bbits[k] - 3))) * 64 + int'(data[5:0]);
      end
      if (m_cap) m_pend = 1'b1;
      else if (m_ap) m_pend = 1'b0;
      m_seen = m_cw;
    end
  end

  function automatic void model_out(input int cfg, input int nb, input int pg, input bit mq,
                                    output bit cs, output int adr);
    int  m    = cfg % 8;
    int  bank = cfg / 8;
    bit  v    = 1'b0;
    int  blk  = 0;
    bit  hit;
    if (m == 1 || m == 3) begin v = (pg == 3); blk = 3; end
    else if (m == 2) begin v = 1'b1; blk = pg; end
    else if (m >= 4) begin v = (pg == 1); blk = m - 4; end
    hit = v && (bank < nb);
    cs  = !(hit && !mq);
    adr = hit ? bank * 4 + blk : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit cs;
    int adr;
    model_out(m_act[0], nbanks[0], int'(adr_hi[7:6]), mreq_b, cs, adr);
    chk("model_cs3",   int'(if3.ramcs_b),  int'(cs));
    chk("model_dis3",  int'(if3.ramdis),   int'(!cs));
    chk("model_adr3",  int'(if3.ramadrhi), adr);
    chk("model_pend3", int'(if3.pend),     int'(m_pend));
    model_out(m_act[1], nbanks[1], int'(adr_hi[7:6]), mreq_b, cs, adr);
    chk("model_cs5",   int'(if5.ramcs_b),  int'(cs));
    chk("model_dis5",  int'(if5.ramdis),   int'(!cs));
    chk("model_adr5",  int'(if5.ramadrhi), adr);
    chk("model_pend5", int'(if5.pend),     int'(m_pend));
  endtask

  task automatic step(input bit rb, input logic [7:0] a, input bit io, input bit mq,
                      input bit w, input logic [7:0] d);
    @(negedge clk);
    reset_b = rb;
    adr_hi  = a;
    iorq_b  = io;
    mreq_b  = mq;
    wr_b    = w;
    data    = d;
    #1;
    check_model();
  endtask

  typedef struct {
    bit         rb;
    logic [7:0] a;
    bit         io, mq, w;
    logic [7:0] d;
    bit         cs;
    logic [4:0] adr;
    bit         pd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset_b = 1'b0;
    adr_hi  = 8'h00;
    iorq_b  = 1'b1;
    mreq_b  = 1'b1;
    wr_b    = 1'b1;
    data    = 8'h00;

    // Reset state for every page, then a 3-cycle config strobe and reads through the new map.
    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 5'b00000, 1'b0};
    tbl[1] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 5'b00000, 1'b0};
    tbl[2] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 5'b00000, 1'b0};
    tbl[3] = '{1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 5'b00000, 1'b0};
    tbl[4] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 8'hC2, 1'b1, 5'b00000, 1'b0};
    tbl[5] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 8'hC2, 1'b1, 5'b00000, 1'b1};
    tbl[6] = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 8'hC2, 1'b1, 5'b00001, 1'b0};
    tbl[7] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 5'b00010, 1'b0};
    tbl[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 5'b00000, 1'b0};
    tbl[9] = '{1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 5'b00011, 1'b0};

    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rb, tbl[i].a, tbl[i].io, tbl[i].mq, tbl[i].w, tbl[i].d);
      chk($sformatf("tbl%0d_cs", i),   int'(if3.ramcs_b),  int'(tbl[i].cs));
      chk($sformatf("tbl%0d_dis", i),  int'(if3.ramdis),   int'(!tbl[i].cs));
      chk($sformatf("tbl%0d_adr", i),  int'(if3.ramadrhi), int'(tbl[i].adr));
      chk($sformatf("tbl%0d_pend", i), int'(if3.pend),     int'(tbl[i].pd));
    end

    // Extended bank bits: bank 24 is unpopulated, bank 16 is not.
    step(1'b1, 8'h7B, 1'b0, 1'b1, 1'b0, 8'hC4);
    step(1'b1, 8'h7B, 1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("bank24_cs", int'(if5.ramcs_b), 1);
    chk("bank24_adr", int'(if5.ramadrhi), 0);
    step(1'b1, 8'h7A, 1'b0, 1'b1, 1'b0, 8'hC4);
    step(1'b1, 8'h7A, 1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("bank16_cs", int'(if5.ramcs_b), 0);
    chk("bank16_adr", int'(if5.ramadrhi), 7'b1000000);

    // Capture during an active memory access.
    step(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 8'hC1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 8'h00);
`ifdef MREQ_DEFER_EN
      chk($sformatf("defer_pend%0d", i), int'(if3.pend), 1);
      chk($sformatf("defer_oldmap%0d", i), int'(if3.ramcs_b), 1);
`else
      chk($sformatf("nodefer_pend%0d", i), int'(if3.pend), (i == 0) ? 1 : 0);
`endif
    end
    step(1'b1, 8'hC0, 1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("c1_pend", int'(if3.pend), 0);
    chk("c1_cs", int'(if3.ramcs_b), 0);
    chk("c1_adr", int'(if3.ramadrhi), 5'b00011);

    // Two captures in a row: the later one is what ends up live.
    step(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 8'hC5);
    step(1'b1, 8'h3F, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 8'hC7);
    step(1'b1, 8'h3F, 1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 8'h3F, 1'b1, 1'b1, 1'b1, 8'h00);
    step(1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("c7_cs", int'(if3.ramcs_b), 0);
    chk("c7_adr", int'(if3.ramadrhi), 5'b00011);

    // Reset while a configuration is pending.
    step(1'b1, 8'h3F, 1'b0, 1'b1, 1'b0, 8'hC2);
    step(1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("prerst_pend", int'(if3.pend), 1);
    step(1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00);
    chk("rst_pend", int'(if3.pend), 0);
    chk("rst_cs", int'(if3.ramcs_b), 1);
    chk("rst_adr", int'(if3.ramadrhi), 0);
    step(1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bit         rb, io, w, mq;
      logic [7:0] a, d;
      rb = ($urandom_range(0, 59) != 0);
      io = ($urandom_range(0, 2) != 0);
      w  = ($urandom_range(0, 2) != 0);
      mq = ($urandom_range(0, 1) != 0);
      a  = 8'($urandom);
      if ($urandom_range(0, 1) == 0) a[7] = 1'b0;
      d  = 8'($urandom);
      if ($urandom_range(0, 2) != 0) d[7:6] = 2'b11;
      step(rb, a, io, mq, w, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
